// File: rtl/decode_stage.sv
// Instruction-decode stage: instruction queue in front of a registered decode bundle
// with a valid/ready handshake toward execute, load-use stall, flush and illegal detection.
module decode_stage #(
  parameter int unsigned IQ_DEPTH = 4,
  parameter bit          RV32E    = 1'b0
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      flush_i,
  input  logic                      fetch_valid_i,
  output logic                      fetch_ready_o,
  input  logic [31:0]               fetch_inst_i,
  input  logic [31:0]               fetch_pc_i,
  input  logic                      ex_is_load_i,
  input  logic [4:0]                ex_rd_addr_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [31:0]               out_pc_o,
  output logic [31:0]               out_inst_o,
  output logic [4:0]                out_rd_addr_o,
  output logic [4:0]                out_rs1_addr_o,
  output logic [4:0]                out_rs2_addr_o,
  output logic                      out_rs1_used_o,
  output logic                      out_rs2_used_o,
  output logic                      out_rd_we_o,
  output logic [31:0]               out_imm_o,
  output logic [3:0]                out_class_o,
  output logic                      out_illegal_o,
  output logic [$clog2(IQ_DEPTH):0] iq_count_o
);

  localparam int unsigned PTR_W = $clog2(IQ_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
  localparam logic [6:0] OPC_MISCMEM = 7'b0001111;

  localparam logic [6:0]  F7_ZERO    = 7'b0000000;
  localparam logic [6:0]  F7_ALT     = 7'b0100000;
  localparam logic [31:0] INST_ECALL = 32'h0000_0073;
  localparam logic [31:0] INST_MRET  = 32'h3020_0073;

  typedef enum logic [3:0] {
    CLS_ALU_R   = 4'd0,
    CLS_ALU_I   = 4'd1,
    CLS_LOAD    = 4'd2,
    CLS_STORE   = 4'd3,
    CLS_BRANCH  = 4'd4,
    CLS_JAL     = 4'd5,
    CLS_JALR    = 4'd6,
    CLS_LUI     = 4'd7,
    CLS_AUIPC   = 4'd8,
    CLS_CSR     = 4'd9,
    CLS_ECALL   = 4'd10,
    CLS_MRET    = 4'd11,
    CLS_FENCE   = 4'd12,
    CLS_ILLEGAL = 4'd15
  } cls_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_used;
    logic        rs2_used;
    logic        rd_we;
    logic [31:0] imm;
    logic [3:0]  cls;
  } bundle_t;

  logic [31:0]      iq_inst [IQ_DEPTH];
  logic [31:0]      iq_pc   [IQ_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic             out_reg_v;
  bundle_t          bundle_q;
  bundle_t          dec;

  logic             push;
  logic             capture;
  logic             hazard;

  logic [31:0]      head_inst;
  logic [31:0]      head_pc;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [31:0]      imm_i;
  logic [31:0]      imm_s;
  logic [31:0]      imm_b;
  logic [31:0]      imm_u;
  logic [31:0]      imm_j;

  cls_e             cls;
  logic [31:0]      imm;
  logic             use_rs1;
  logic             use_rs2;
  logic             writes_rd;
  logic             rv32e_bad;

  assign fetch_ready_o = (count_q != CNT_W'(IQ_DEPTH));
  assign push          = fetch_valid_i & fetch_ready_o & ~flush_i;
  assign capture       = (count_q != '0) & ~flush_i & (~out_reg_v | (out_valid_o & out_ready_i));
  assign iq_count_o    = count_q;

  assign head_inst = iq_inst[rd_ptr_q];
  assign head_pc   = iq_pc[rd_ptr_q];
  assign opcode    = head_inst[6:0];
  assign funct3    = head_inst[14:12];
  assign funct7    = head_inst[31:25];

  assign imm_i = {{20{head_inst[31]}}, head_inst[31:20]};
  assign imm_s = {{20{head_inst[31]}}, head_inst[31:25], head_inst[11:7]};
  assign imm_b = {{19{head_inst[31]}}, head_inst[31], head_inst[7], head_inst[30:25],
                  head_inst[11:8], 1'b0};
  assign imm_u = {head_inst[31:12], 12'h000};
  assign imm_j = {{11{head_inst[31]}}, head_inst[31], head_inst[19:12], head_inst[20],
                  head_inst[30:21], 1'b0};

  // Queue storage needs no reset: occupancy is tracked by count_q alone.
  always_ff @(posedge clk_i) begin
    if (push) begin
      iq_inst[wr_ptr_q] <= fetch_inst_i;
      iq_pc[wr_ptr_q]   <= fetch_pc_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push)    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (capture) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push) - CNT_W'(capture);
    end
  end

  // Opcode/funct legality, class, immediate format and operand usage of the queue head.
  always_comb begin
    cls       = CLS_ILLEGAL;
    imm       = '0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    writes_rd = 1'b0;
    case (opcode)
      OPC_OP: begin
        if (funct7 == F7_ZERO ||
            (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          cls       = CLS_ALU_R;
          use_rs1   = 1'b1;
          use_rs2   = 1'b1;
          writes_rd = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        if ((funct3 != 3'b001 && funct3 != 3'b101) || funct7 == F7_ZERO ||
            (funct3 == 3'b101 && funct7 == F7_ALT)) begin
          cls       = CLS_ALU_I;
          imm       = imm_i;
          use_rs1   = 1'b1;
          writes_rd = 1'b1;
        end
      end
      OPC_LOAD: begin
        if (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) begin
          cls       = CLS_LOAD;
          imm       = imm_i;
          use_rs1   = 1'b1;
          writes_rd = 1'b1;
        end
      end
      OPC_STORE: begin
        if (funct3 inside {3'b000, 3'b001, 3'b010}) begin
          cls     = CLS_STORE;
          imm     = imm_s;
          use_rs1 = 1'b1;
          use_rs2 = 1'b1;
        end
      end
      OPC_BRANCH: begin
        if (funct3 != 3'b010 && funct3 != 3'b011) begin
          cls     = CLS_BRANCH;
          imm     = imm_b;
          use_rs1 = 1'b1;
          use_rs2 = 1'b1;
        end
      end
      OPC_JAL: begin
        cls       = CLS_JAL;
        imm       = imm_j;
        writes_rd = 1'b1;
      end
      OPC_JALR: begin
        if (funct3 == 3'b000) begin
          cls       = CLS_JALR;
          imm       = imm_i;
          use_rs1   = 1'b1;
          writes_rd = 1'b1;
        end
      end
      OPC_LUI: begin
        cls       = CLS_LUI;
        imm       = imm_u;
        writes_rd = 1'b1;
      end
      OPC_AUIPC: begin
        cls       = CLS_AUIPC;
        imm       = imm_u;
        writes_rd = 1'b1;
      end
      OPC_SYSTEM: begin
        if (head_inst == INST_ECALL) begin
          cls = CLS_ECALL;
          imm = imm_i;
        end else if (head_inst == INST_MRET) begin
          cls = CLS_MRET;
          imm = imm_i;
        end else if (funct3 != 3'b000 && funct3 != 3'b100) begin
          // funct3[2] selects the zimm forms, where the rs1 field is not a register
          cls       = CLS_CSR;
          imm       = imm_i;
          use_rs1   = ~funct3[2];
          writes_rd = 1'b1;
        end
      end
      OPC_MISCMEM: begin
        if (funct3 == 3'b000 || funct3 == 3'b001) begin
          cls = CLS_FENCE;
          imm = imm_i;
        end
      end
      default: ;
    endcase
  end

  assign rv32e_bad = RV32E && ((use_rs1 && head_inst[19]) ||
                               (use_rs2 && head_inst[24]) ||
                               (writes_rd && head_inst[11]));

  // Illegal bundles drop every side effect and carry a zero immediate.
  always_comb begin
    dec      = '0;
    dec.pc   = head_pc;
    dec.inst = head_inst;
    dec.rd   = head_inst[11:7];
    dec.rs1  = head_inst[19:15];
    dec.rs2  = head_inst[24:20];
    dec.cls  = CLS_ILLEGAL;
    if (cls != CLS_ILLEGAL && !rv32e_bad) begin
      dec.cls      = cls;
      dec.imm      = imm;
      dec.rs1_used = use_rs1;
      dec.rs2_used = use_rs2;
      dec.rd_we    = writes_rd & (head_inst[11:7] != 5'd0);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_reg_v <= 1'b0;
      bundle_q  <= '0;
    end else if (flush_i) begin
      out_reg_v <= 1'b0;
    end else if (capture) begin
      out_reg_v <= 1'b1;
      bundle_q  <= dec;
    end else if (out_valid_o && out_ready_i) begin
      out_reg_v <= 1'b0;
    end
  end

  assign hazard = out_reg_v & ex_is_load_i & (ex_rd_addr_i != 5'd0) &
                  ((bundle_q.rs1_used & (bundle_q.rs1 == ex_rd_addr_i)) |
                   (bundle_q.rs2_used & (bundle_q.rs2 == ex_rd_addr_i)));

  assign out_valid_o    = out_reg_v & ~hazard;
  assign out_pc_o       = bundle_q.pc;
  assign out_inst_o     = bundle_q.inst;
  assign out_rd_addr_o  = bundle_q.rd;
  assign out_rs1_addr_o = bundle_q.rs1;
  assign out_rs2_addr_o = bundle_q.rs2;
  assign out_rs1_used_o = bundle_q.rs1_used;
  assign out_rs2_used_o = bundle_q.rs2_used;
  assign out_rd_we_o    = bundle_q.rd_we;
  assign out_imm_o      = bundle_q.imm;
  assign out_class_o    = bundle_q.cls;
  assign out_illegal_o  = (bundle_q.cls == CLS_ILLEGAL);

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus a randomized run against a
// spec-level model (class table, in-flight instruction queue, occupancy counters).
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        fetch_valid;
  logic [31:0] fetch_inst;
  logic [31:0] fetch_pc;
  logic        ex_is_load;
  logic [4:0]  ex_rd;
  logic        out_ready;

  logic        fetch_ready, out_valid, rs1_used, rs2_used, rd_we, illegal;
  logic [31:0] out_pc, out_inst, out_imm;
  logic [4:0]  rd_addr, rs1_addr, rs2_addr;
  logic [3:0]  out_class;
  logic [2:0]  iq_count;

  logic        e_fetch_ready, e_out_valid, e_rs1_used, e_rs2_used, e_rd_we, e_illegal;
  logic [31:0] e_out_pc, e_out_inst, e_out_imm;
  logic [4:0]  e_rd_addr, e_rs1_addr, e_rs2_addr;
  logic [3:0]  e_out_class;
  logic [2:0]  e_iq_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_stage #(.IQ_DEPTH(4), .RV32E(1'b0)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
    .fetch_valid_i(fetch_valid), .fetch_ready_o(fetch_ready),
    .fetch_inst_i(fetch_inst), .fetch_pc_i(fetch_pc),
    .ex_is_load_i(ex_is_load), .ex_rd_addr_i(ex_rd),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_pc_o(out_pc), .out_inst_o(out_inst),
    .out_rd_addr_o(rd_addr), .out_rs1_addr_o(rs1_addr), .out_rs2_addr_o(rs2_addr),
    .out_rs1_used_o(rs1_used), .out_rs2_used_o(rs2_used), .out_rd_we_o(rd_we),
    .out_imm_o(out_imm), .out_class_o(out_class), .out_illegal_o(illegal),
    .iq_count_o(iq_count)
  );

  decode_stage #(.IQ_DEPTH(4), .RV32E(1'b1)) dut_e (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
    .fetch_valid_i(fetch_valid), .fetch_ready_o(e_fetch_ready),
    .fetch_inst_i(fetch_inst), .fetch_pc_i(fetch_pc),
    .ex_is_load_i(ex_is_load), .ex_rd_addr_i(ex_rd),
    .out_valid_o(e_out_valid), .out_ready_i(out_ready),
    .out_pc_o(e_out_pc), .out_inst_o(e_out_inst),
    .out_rd_addr_o(e_rd_addr), .out_rs1_addr_o(e_rs1_addr), .out_rs2_addr_o(e_rs2_addr),
    .out_rs1_used_o(e_rs1_used), .out_rs2_used_o(e_rs2_used), .out_rd_we_o(e_rd_we),
    .out_imm_o(e_out_imm), .out_class_o(e_out_class), .out_illegal_o(e_illegal),
    .iq_count_o(e_iq_count)
  );

  typedef struct packed {
    logic [3:0]  cls;
    logic [31:0] imm;
    logic        rd_we;
    logic        u1;
    logic        u2;
  } ref_t;

  // Reference decode: classify first, then derive format and operand use from the class.
  function automatic ref_t ref_decode(input logic [31:0] w, input bit rv32e);
    ref_t r;
    logic [2:0] f3;
    logic [6:0] f7;
    bit wr;
    f3 = w[14:12];
    f7 = w[31:25];
    r = '0;
    r.cls = 4'd15;
    case (w[6:0])
      7'h33: if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) r.cls = 4'd0;
      7'h13: begin
        if (f3 == 3'd1)      r.cls = (f7 == 7'h00) ? 4'd1 : 4'd15;
        else if (f3 == 3'd5) r.cls = (f7 == 7'h00 || f7 == 7'h20) ? 4'd1 : 4'd15;
        else                 r.cls = 4'd1;
      end
      7'h03: r.cls = (f3 == 3'd3 || f3 >= 3'd6) ? 4'd15 : 4'd2;
      7'h23: r.cls = (f3 <= 3'd2) ? 4'd3 : 4'd15;
      7'h63: r.cls = (f3 == 3'd2 || f3 == 3'd3) ? 4'd15 : 4'd4;
      7'h6F: r.cls = 4'd5;
      7'h67: r.cls = (f3 == 3'd0) ? 4'd6 : 4'd15;
      7'h37: r.cls = 4'd7;
      7'h17: r.cls = 4'd8;
      7'h73: begin
        if (w == 32'h0000_0073)                r.cls = 4'd10;
        else if (w == 32'h3020_0073)           r.cls = 4'd11;
        else if (f3 != 3'd0 && f3 != 3'd4)     r.cls = 4'd9;
      end
      7'h0F: r.cls = (f3 <= 3'd1) ? 4'd12 : 4'd15;
      default: ;
    endcase
    wr   = r.cls inside {4'd0, 4'd1, 4'd2, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
    r.u1 = (r.cls inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6}) || (r.cls == 4'd9 && f3 < 3'd4);
    r.u2 = r.cls inside {4'd0, 4'd3, 4'd4};
    case (r.cls)
      4'd1, 4'd2, 4'd6, 4'd9, 4'd10, 4'd11, 4'd12: r.imm = {{20{w[31]}}, w[31:20]};
      4'd3: r.imm = {{20{w[31]}}, w[31:25], w[11:7]};
      4'd4: r.imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      4'd5: r.imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      4'd7, 4'd8: r.imm = {w[31:12], 12'h000};
      default: r.imm = 32'h0;
    endcase
    if (rv32e && ((r.u1 && w[19]) || (r.u2 && w[24]) || (wr && w[11]))) r.cls = 4'd15;
    if (r.cls == 4'd15) begin
      r.imm = 32'h0; r.u1 = 1'b0; r.u2 = 1'b0; wr = 1'b0;
    end
    r.rd_we = wr && (w[11:7] != 5'd0);
    return r;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 11))
      0: w[6:0] = 7'h33;  1: w[6:0] = 7'h13;  2: w[6:0] = 7'h03;  3: w[6:0] = 7'h23;
      4: w[6:0] = 7'h63;  5: w[6:0] = 7'h6F;  6: w[6:0] = 7'h67;  7: w[6:0] = 7'h37;
      8: w[6:0] = 7'h17;  9: w[6:0] = 7'h73;  10: w[6:0] = 7'h0F;
      default: ;
    endcase
    if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h00 : 7'h20;
    if ($urandom_range(0, 1) == 1) begin
      w[19:15] = 5'($urandom_range(0, 3));
      w[24:20] = 5'($urandom_range(0, 3));
    end
    case ($urandom_range(0, 15))
      0: w = 32'h0000_0073;
      1: w = 32'h3020_0073;
      default: ;
    endcase
    return w;
  endfunction

  task automatic push(input logic [31:0] pc, input logic [31:0] inst);
    fetch_valid = 1'b1; fetch_pc = pc; fetch_inst = inst;
    @(posedge clk); #1;
    fetch_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; fetch_valid = 1'b0; fetch_inst = '0; fetch_pc = '0;
    ex_is_load = 1'b0; ex_rd = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0)     begin errors++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
    checks++; if (iq_count !== 3'd0)      begin errors++; $display("FAIL reset_count: got %0d want 0", iq_count); end
    checks++; if (fetch_ready !== 1'b1)   begin errors++; $display("FAIL reset_ready: got %0b want 1", fetch_ready); end
    checks++; if (out_class !== 4'd0 || illegal !== 1'b0 || out_pc !== 32'h0 || out_imm !== 32'h0)
      begin errors++; $display("FAIL reset_bundle: class %0d ill %0b pc %h imm %h want all 0", out_class, illegal, out_pc, out_imm); end
    #3 rst_n = 1'b1;
  endtask

  task automatic test_addi();
    out_ready = 1'b1;
    push(32'h100, 32'h0050_0093);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL addi_latency1: got valid %0b want 0", out_valid); end
    checks++; if (iq_count !== 3'd1)  begin errors++; $display("FAIL addi_count1: got %0d want 1", iq_count); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid: got %0b want 1", out_valid); end
    checks++; if (out_class !== 4'd1 || out_imm !== 32'd5 || rd_addr !== 5'd1 || out_pc !== 32'h100)
      begin errors++; $display("FAIL addi_fields: class %0d imm %h rd %0d pc %h want 1 5 1 100", out_class, out_imm, rd_addr, out_pc); end
    checks++; if (rd_we !== 1'b1 || rs1_used !== 1'b1 || rs2_used !== 1'b0 || illegal !== 1'b0)
      begin errors++; $display("FAIL addi_flags: we %0b u1 %0b u2 %0b ill %0b want 1 1 0 0", rd_we, rs1_used, rs2_used, illegal); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL addi_consumed: got valid %0b want 0", out_valid); end
  endtask

  task automatic test_fill_wrap();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(32'h200 + 32'(i * 4), {12'(i), 5'd0, 3'd0, 5'(i + 1), 7'h13});
    checks++; if (iq_count !== 3'd4)     begin errors++; $display("FAIL fill_count: got %0d want 4", iq_count); end
    checks++; if (fetch_ready !== 1'b0)  begin errors++; $display("FAIL fill_ready: got %0b want 0", fetch_ready); end
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h200)
      begin errors++; $display("FAIL fill_head: valid %0b pc %h want 1 200", out_valid, out_pc); end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h200 + 32'(i * 4) || out_imm !== 32'(i))
        begin errors++; $display("FAIL wrap_order%0d: valid %0b pc %h imm %h want 1 %h %h", i, out_valid, out_pc, out_imm, 32'h200 + 32'(i * 4), i); end
      @(posedge clk); #1;
      if (i == 0) begin
        checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL fill_recover: got %0b want 1", fetch_ready); end
      end
    end
    checks++; if (out_valid !== 1'b0 || iq_count !== 3'd0)
      begin errors++; $display("FAIL wrap_drained: valid %0b count %0d want 0 0", out_valid, iq_count); end
  endtask

  task automatic test_illegal();
    logic [31:0] tbl [4];
    logic [3:0]  cls0 [4];
    logic [3:0]  clse [4];
    tbl  = '{32'hFFFF_FFFF, 32'h0020_A063, 32'h0220_81B3, 32'h0020_88B3};
    cls0 = '{4'd15, 4'd15, 4'd15, 4'd0};
    clse = '{4'd15, 4'd15, 4'd15, 4'd15};
    out_ready = 1'b1;
    for (int c = 0; c <= 4; c++) begin
      fetch_valid = (c < 4);
      if (c < 4) begin fetch_inst = tbl[c]; fetch_pc = 32'h700 + 32'(c * 4); end
      @(posedge clk); #1;
      if (c >= 1) begin
        checks++; if (out_valid !== 1'b1 || out_class !== cls0[c-1] || illegal !== (cls0[c-1] == 4'd15))
          begin errors++; $display("FAIL illegal_cls%0d: valid %0b class %0d ill %0b want class %0d", c - 1, out_valid, out_class, illegal, cls0[c-1]); end
        checks++; if (rd_we !== (cls0[c-1] != 4'd15) || (cls0[c-1] == 4'd15 && (rs1_used | rs2_used) !== 1'b0))
          begin errors++; $display("FAIL illegal_we%0d: we %0b u1 %0b u2 %0b", c - 1, rd_we, rs1_used, rs2_used); end
        checks++; if (e_out_class !== clse[c-1] || e_illegal !== 1'b1 || e_rd_we !== 1'b0)
          begin errors++; $display("FAIL rv32e_cls%0d: class %0d ill %0b we %0b want 15 1 0", c - 1, e_out_class, e_illegal, e_rd_we); end
      end
    end
    fetch_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_hazard();
    out_ready = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd2;
    push(32'h300, 32'h0020_81B3);
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || out_pc !== 32'h300)
      begin errors++; $display("FAIL hazard_stall: valid %0b pc %h want 0 300", out_valid, out_pc); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || out_pc !== 32'h300 || iq_count !== 3'd0)
      begin errors++; $display("FAIL hazard_hold: valid %0b pc %h count %0d want 0 300 0", out_valid, out_pc, iq_count); end
    ex_is_load = 1'b0; #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hazard_release: got %0b want 1", out_valid); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hazard_consume: got %0b want 0", out_valid); end
    ex_is_load = 1'b1; ex_rd = 5'd0;
    push(32'h304, 32'h0000_01B3);
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h304)
      begin errors++; $display("FAIL hazard_x0: valid %0b pc %h want 1 304", out_valid, out_pc); end
    @(posedge clk); #1;
    ex_is_load = 1'b0;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(32'h400 + 32'(i * 4), 32'h0010_0093);
    checks++; if (iq_count !== 3'd3 || out_valid !== 1'b1)
      begin errors++; $display("FAIL flush_pre: count %0d valid %0b want 3 1", iq_count, out_valid); end
    flush = 1'b1; fetch_valid = 1'b1; fetch_pc = 32'h500; fetch_inst = 32'h0070_0093;
    @(posedge clk); #1;
    flush = 1'b0; fetch_valid = 1'b0;
    checks++; if (iq_count !== 3'd0 || out_valid !== 1'b0)
      begin errors++; $display("FAIL flush_clear: count %0d valid %0b want 0 0", iq_count, out_valid); end
    out_ready = 1'b1;
    push(32'h600, 32'h0090_0113);
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h600 || out_class !== 4'd1 || out_imm !== 32'd9 || rd_addr !== 5'd2)
      begin errors++; $display("FAIL flush_next: valid %0b pc %h class %0d imm %h rd %0d", out_valid, out_pc, out_class, out_imm, rd_addr); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || iq_count !== 3'd0)
      begin errors++; $display("FAIL flush_dropped: valid %0b count %0d want 0 0", out_valid, iq_count); end
  endtask

  task automatic test_classes();
    logic [31:0] tbl  [8];
    logic [3:0]  cls  [8];
    logic [31:0] imm  [8];
    logic        we   [8];
    tbl = '{32'hFFFF_F2B7, 32'h8000_0317, 32'hFFDF_F0EF, 32'hFF80_8067,
            32'hFE20_AE23, 32'hF140_2573, 32'h0000_0073, 32'h3020_0073};
    cls = '{4'd7, 4'd8, 4'd5, 4'd6, 4'd3, 4'd9, 4'd10, 4'd11};
    imm = '{32'hFFFF_F000, 32'h8000_0000, 32'hFFFF_FFFC, 32'hFFFF_FFF8,
            32'hFFFF_FFFC, 32'hFFFF_FF14, 32'h0000_0000, 32'h0000_0302};
    we  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    out_ready = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      fetch_valid = (c < 8);
      if (c < 8) begin fetch_inst = tbl[c]; fetch_pc = 32'h800 + 32'(c * 4); end
      @(posedge clk); #1;
      if (c >= 1) begin
        checks++; if (out_valid !== 1'b1 || out_class !== cls[c-1] || out_imm !== imm[c-1] || rd_we !== we[c-1])
          begin errors++; $display("FAIL class%0d: valid %0b class %0d imm %h we %0b want 1 %0d %h %0b", c - 1, out_valid, out_class, out_imm, rd_we, cls[c-1], imm[c-1], we[c-1]); end
      end
    end
    fetch_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    push(32'h900, 32'h0010_0093);
    push(32'h904, 32'h0010_0093);
    #2 rst_n = 1'b0; #1;
    checks++; if (iq_count !== 3'd0 || out_valid !== 1'b0 || out_pc !== 32'h0)
      begin errors++; $display("FAIL async_reset: count %0d valid %0b pc %h want 0 0 0", iq_count, out_valid, out_pc); end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [63:0] q[$];
    logic [63:0] head;
    ref_t f;
    int   cnt;
    bit   outv, haz, vm, psh, pop, cap;
    cnt = 0; outv = 1'b0;
    for (int c = 0; c < 620; c++) begin
      if (c < 600) begin
        fetch_valid = ($urandom_range(0, 9) < 7);
        fetch_inst  = rand_inst();
        out_ready   = ($urandom_range(0, 9) < 6);
        ex_is_load  = ($urandom_range(0, 2) == 0);
        ex_rd       = 5'($urandom_range(0, 3));
        flush       = ($urandom_range(0, 39) == 0);
      end else begin
        fetch_valid = 1'b0; out_ready = 1'b1; ex_is_load = 1'b0; flush = 1'b0;
      end
      fetch_pc = 32'h1000 + 32'(c * 4);
      @(negedge clk);
      haz = 1'b0;
      head = '0;
      f = '0;
      if (outv) begin
        head = q[0];
        f = ref_decode(head[31:0], 1'b0);
        haz = ex_is_load && ex_rd != 5'd0 &&
              ((f.u1 && head[19:15] == ex_rd) || (f.u2 && head[24:20] == ex_rd));
      end
      vm = outv && !haz;
      checks++; if (out_valid !== vm || fetch_ready !== (cnt < 4) || iq_count !== 3'(cnt))
        begin errors++; $display("FAIL rnd_ctrl c%0d: valid %0b ready %0b count %0d want %0b %0b %0d", c, out_valid, fetch_ready, iq_count, vm, cnt < 4, cnt); end
      if (outv) begin
        checks++; if (out_pc !== head[63:32] || out_inst !== head[31:0] || out_class !== f.cls || out_imm !== f.imm)
          begin errors++; $display("FAIL rnd_bundle c%0d: pc %h inst %h class %0d imm %h want %h %h %0d %h", c, out_pc, out_inst, out_class, out_imm, head[63:32], head[31:0], f.cls, f.imm); end
        checks++; if (rd_we !== f.rd_we || rs1_used !== f.u1 || rs2_used !== f.u2 || illegal !== (f.cls == 4'd15) ||
                      rd_addr !== head[11:7] || rs1_addr !== head[19:15] || rs2_addr !== head[24:20])
          begin errors++; $display("FAIL rnd_flags c%0d: we %0b u1 %0b u2 %0b ill %0b want %0b %0b %0b", c, rd_we, rs1_used, rs2_used, illegal, f.rd_we, f.u1, f.u2); end
      end
      psh = fetch_valid && cnt < 4 && !flush;
      pop = vm && out_ready;
      cap = cnt > 0 && !flush && (!outv || pop);
      @(posedge clk); #1;
      if (flush) begin
        q.delete(); cnt = 0; outv = 1'b0;
      end else begin
        if (pop) void'(q.pop_front());
        if (psh) q.push_back({fetch_pc, fetch_inst});
        cnt  = cnt + int'(psh) - int'(cap);
        outv = cap ? 1'b1 : (pop ? 1'b0 : outv);
      end
    end
    checks++; if (out_valid !== 1'b0 || iq_count !== 3'd0)
      begin errors++; $display("FAIL rnd_drain: valid %0b count %0d want 0 0", out_valid, iq_count); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_fill_wrap();
    test_illegal();
    test_hazard();
    test_flush();
    test_classes();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
